tap_delay_line: RTL and testbench
=================================

TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of delay stages (DEPTH >= 2).
REQ-003 SHALL have parameter SW, default $clog2(DEPTH), meaning width of tap_sel.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, meaning shift enable: the line advances one stage only on cycles with en=1.
REQ-007 SHALL have port in, input, WIDTH, meaning sample written into stage 0.
REQ-008 SHALL have port in_valid, input, 1, meaning a valid tag travels with `in`.
REQ-009 SHALL have port flush, input, 1, meaning invalidate all stored samples.
REQ-010 SHALL have port tap_sel, input, SW, meaning runtime tap index.
REQ-011 SHALL have port out, output, WIDTH, meaning data at the selected tap.
REQ-012 SHALL have port out_valid, output, 1, meaning valid tag at the selected tap.
REQ-013 SHALL have port out2, output, WIDTH, meaning data at the last stage (fixed DEPTH delay).
REQ-014 SHALL have port out2_valid, output, 1, meaning valid tag at the last stage.
REQ-015 SHALL have port fill, output, $clog2(DEPTH+1), meaning count of valid stages.

Function
REQ-016 SHALL hold stages 0..DEPTH-1, each storing WIDTH data bits plus 1 valid bit.
REQ-017 SHALL, on a clock edge with en=1, load stage0 with {in, in_valid} and stage i with stage i-1 for i = 1..DEPTH-1.
REQ-018 SHALL hold all stages unchanged when en=0, regardless of in and in_valid.
REQ-019 SHALL drive out/out_valid combinationally from stage[tap_sel], so a sample appears tap_sel+1 enabled cycles after capture.
REQ-020 SHALL clamp any tap_sel >= DEPTH to DEPTH-1, never driving X.
REQ-021 SHALL drive out2/out2_valid from stage[DEPTH-1], giving a latency of DEPTH enabled cycles.
REQ-022 SHALL, on flush=1 with en=0, clear every valid bit and leave data bits unchanged.
REQ-023 SHALL, on flush=1 with en=1, clear every valid bit, then load stage0 with {in, in_valid}; the new sample survives the flush.
REQ-024 SHALL keep fill equal to the population count of the valid bits after every edge.
REQ-025 SHALL update fill incrementally as fill + in_valid − stage[DEPTH-1].valid on a shift, and set it to in_valid on flush with en=1.
REQ-026 SHALL never exceed DEPTH or go below 0 in fill.
REQ-027 SHALL discard the last-stage sample without error when the line is full and shifting; there is no backpressure.
REQ-028 SHALL apply tap_sel changes immediately; stored contents are unaffected.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear all data and valid bits to 0 and set fill to 0.
REQ-030 SHALL give rst priority over flush and en.
REQ-031 SHALL, after reset, drive out=0, out_valid=0, out2=0, out2_valid=0 and fill=0.
REQ-032 SHALL, on reset asserted mid-stream, discard all in-flight samples; the first post-reset shift behaves as from empty.

Structure
REQ-033 SHALL place the default WIDTH/DEPTH constants and the fill-width function in a shared package, delay_pkg.
REQ-034 SHALL implement one sub-module, delay_stage: a WIDTH+1 bit register with en, flush-clear of the valid bit, and sync reset, instantiated DEPTH times through generate.
REQ-035 SHALL keep the tap mux, the clamp and the fill counter in the top level.

Verification (WIDTH=4, DEPTH=8)
REQ-036 SHALL cover reset: rst held 2 cycles, then en=1, in=4'hA, in_valid=1 -> out2=4'hA with out2_valid=1 exactly 8 enabled cycles later, and 0/0 before that.
REQ-037 SHALL cover enable gating: en pattern 1,0,1 with in=4'b1010, 4'b0101, 4'b0011, tap_sel=1 -> out=4'b1010 after the third edge, and 4'b0101 is never captured.
REQ-038 SHALL cover tap sweep: stream 0..F continuously with tap_sel stepped 0..7 and then set to 3'd7 -> out equals the sample from tap_sel+1 cycles earlier; tap_sel=7 matches out2.
REQ-039 SHALL cover flush: with fill=8, pulse flush with en=1, in=4'h5, in_valid=1 -> fill=1, out_valid=1 only at tap 0, and out2_valid=0.
REQ-040 SHALL cover fill accounting: alternate in_valid 1,0 for 20 shifts -> fill saturates at 4 and never exceeds 8.
REQ-041 SHALL cover mid-stream reset: rst at cycle 5 of streaming -> all outputs 0 next cycle, and the refill latency is 8 again.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared constants and helpers for the tapped delay line.
package delay_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 8;

  // A line of `depth` stages can hold 0..depth valid samples.
  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One delay-line stage: WIDTH data bits plus a valid tag.
// The stage has an enable, a flush that clears the valid bit, and a synchronous reset.
module delay_stage
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A shift overrides the flush. The caller masks d_valid for the stages that
  // must stay invalid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) valid_d = 1'b0;
    if (en) begin
      data_d  = d_data;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/tap_delay_line.sv
// Tapped delay line: DEPTH stages with valid tags, a runtime-selected tap,
// a fixed last-stage output, and a running count of valid stages.
module tap_delay_line
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           in,
  input  logic                       in_valid,
  input  logic                       flush,
  input  logic [SW-1:0]              tap_sel,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out2,
  output logic                       out2_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned FW = fill_w(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0]            stage_valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_data;
    logic             d_valid;

    if (g == 0) begin : g_head
      assign d_data  = in;
      assign d_valid = in_valid;
    end else begin : g_body
      // During a flush the shifted-in valid is dropped, so only stage 0 can
      // come out of a flush-with-shift holding a valid sample.
      assign d_data  = stage_data[g-1];
      assign d_valid = stage_valid[g-1] & ~flush;
    end

    delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .flush  (flush),
      .d_data (d_data),
      .d_valid(d_valid),
      .q_data (stage_data[g]),
      .q_valid(stage_valid[g])
    );
  end

  logic [AW-1:0] sel_c;

  always_comb begin
    if (32'(tap_sel) >= DEPTH) sel_c = AW'(DEPTH - 1);
    else                       sel_c = AW'(tap_sel);
  end

  assign out        = stage_data[sel_c];
  assign out_valid  = stage_valid[sel_c];
  assign out2       = stage_data[DEPTH-1];
  assign out2_valid = stage_valid[DEPTH-1];

  logic [FW-1:0] fill_q, fill_d;

  // On a shift the sample leaving the last stage and the one arriving at
  // stage 0 are the only changes to the population of valid bits.
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      if (flush) fill_d = FW'(in_valid);
      else       fill_d = fill_q + FW'(in_valid) - FW'(stage_valid[DEPTH-1]);
    end else if (flush) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fill_q <= '0;
    else     fill_q <= fill_d;
  end

  assign fill = fill_q;

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed scoreboard bench for tap_delay_line (WIDTH=4, DEPTH=8).
module tb_tap_delay_line;

  localparam logic [4:0] M_OUT  = 5'b00001;
  localparam logic [4:0] M_OV   = 5'b00010;
  localparam logic [4:0] M_O2   = 5'b00100;
  localparam logic [4:0] M_O2V  = 5'b01000;
  localparam logic [4:0] M_FILL = 5'b10000;
  localparam logic [4:0] M_ALL  = 5'b11111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] din = '0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] tap_sel = '0;
  logic [3:0] out;
  logic       out_valid;
  logic [3:0] out2;
  logic       out2_valid;
  logic [3:0] fill;

  tap_delay_line #(
    .WIDTH(4),
    .DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (din),
    .in_valid  (in_valid),
    .flush     (flush),
    .tap_sel   (tap_sel),
    .out       (out),
    .out_valid (out_valid),
    .out2      (out2),
    .out2_valid(out2_valid),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic [4:0] mask;
    logic [3:0] out;
    logic       ov;
    logic [3:0] out2;
    logic       o2v;
    logic [3:0] fill;
  } entry_t;

  entry_t sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic chk(input string nm, input logic [4:0] m,
                     input logic [3:0] eo, input logic eov,
                     input logic [3:0] eo2, input logic eo2v,
                     input logic [3:0] ef);
    entry_t e;
    e.due = cyc; e.name = nm; e.mask = m;
    e.out = eo; e.ov = eov; e.out2 = eo2; e.o2v = eo2v; e.fill = ef;
    sb_q.push_back(e);
  endtask

  entry_t mon_e;
  logic   mon_bad;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e   = sb_q.pop_front();
      n_vec++;
      mon_bad = (mon_e.due != cyc);
      if (mon_e.mask[0] && out        !== mon_e.out)  mon_bad = 1'b1;
      if (mon_e.mask[1] && out_valid  !== mon_e.ov)   mon_bad = 1'b1;
      if (mon_e.mask[2] && out2       !== mon_e.out2) mon_bad = 1'b1;
      if (mon_e.mask[3] && out2_valid !== mon_e.o2v)  mon_bad = 1'b1;
      if (mon_e.mask[4] && fill       !== mon_e.fill) mon_bad = 1'b1;
      if (mon_bad) begin
        n_err++;
        $display("FAIL %s cyc=%0d tap=%0d: got out=%h/%b out2=%h/%b fill=%0d, want out=%h/%b out2=%h/%b fill=%0d (mask %b)",
                 mon_e.name, cyc, tap_sel, out, out_valid, out2, out2_valid, fill,
                 mon_e.out, mon_e.ov, mon_e.out2, mon_e.o2v, mon_e.fill, mon_e.mask);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] samp(input int k);
    return (k >= 0) ? {4'(k), 1'b1} : 5'b0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s_tap, s_last;
    int t;

    // Reset state and fixed 8-cycle latency of a single sample.
    do_reset();
    tap_sel = 3'd0;
    en = 1'b1; din = 4'hA; in_valid = 1'b1;
    chk("reset_state", M_ALL, 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    for (int k = 0; k <= 9; k++) begin
      en = 1'b1;
      din = (k == 0) ? 4'hA : 4'h0;
      in_valid = (k == 0);
      chk("rst_latency", M_O2 | M_O2V | M_FILL, 4'h0, 1'b0,
          (k == 8) ? 4'hA : 4'h0, (k == 8), (k >= 1 && k <= 8) ? 4'd1 : 4'd0);
      step();
    end

    // Enable gating: the middle sample (en=0) is never captured.
    do_reset();
    tap_sel = 3'd1;
    en = 1'b1; din = 4'b1010; in_valid = 1'b1;
    step();
    en = 1'b0; din = 4'b0101; in_valid = 1'b1; tap_sel = 3'd0;
    chk("en_first", M_OUT | M_OV | M_FILL, 4'b1010, 1'b1, 4'h0, 1'b0, 4'd1);
    step();
    en = 1'b1; din = 4'b0011; in_valid = 1'b1;
    chk("en_hold", M_OUT | M_OV | M_FILL, 4'b1010, 1'b1, 4'h0, 1'b0, 4'd1);
    step();
    en = 1'b0; tap_sel = 3'd1;
    chk("en_gate_tap1", M_OUT | M_OV | M_FILL, 4'b1010, 1'b1, 4'h0, 1'b0, 4'd2);
    step();
    tap_sel = 3'd0;
    chk("en_gate_tap0", M_OUT | M_OV, 4'b0011, 1'b1, 4'h0, 1'b0, 4'd0);
    step();
    tap_sel = 3'd2;
    chk("en_gate_tap2", M_OUT | M_OV | M_FILL, 4'h0, 1'b0, 4'h0, 1'b0, 4'd2);
    step();

    // Tap sweep over a continuous stream.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      t = (c < 8) ? 0 : ((c < 16) ? ((c * 3) % 8) : 7);
      en = 1'b1; din = 4'(c); in_valid = 1'b1; tap_sel = 3'(t);
      s_tap  = samp(c - 1 - t);
      s_last = samp(c - 8);
      chk("tap_sweep", M_ALL, s_tap[4:1], s_tap[0], s_last[4:1], s_last[0],
          (c < 8) ? 4'(c) : 4'd8);
      step();
    end

    // Flush with a shift on a full line, then flush without a shift.
    en = 1'b1; flush = 1'b1; din = 4'h5; in_valid = 1'b1; tap_sel = 3'd0;
    chk("pre_flush_fill", M_FILL, 4'h0, 1'b0, 4'h0, 1'b0, 4'd8);
    step();
    flush = 1'b0; en = 1'b0;
    chk("flush_tap0", M_OUT | M_OV | M_O2V | M_FILL, 4'h5, 1'b1, 4'h0, 1'b0, 4'd1);
    step();
    tap_sel = 3'd1;
    chk("flush_tap1", M_OV, 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    step();
    tap_sel = 3'd7;
    chk("flush_tap7", M_OV | M_O2V, 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    step();
    flush = 1'b1; en = 1'b0; tap_sel = 3'd0;
    chk("flush_noen_pre", M_OUT | M_OV | M_FILL, 4'h5, 1'b1, 4'h0, 1'b0, 4'd1);
    step();
    flush = 1'b0;
    chk("flush_noen", M_OUT | M_OV | M_FILL, 4'h5, 1'b0, 4'h0, 1'b0, 4'd0);
    step();

    // Fill accounting with alternating valid tags.
    do_reset();
    tap_sel = 3'd0;
    for (int n = 0; n <= 20; n++) begin
      en = 1'b1; din = 4'(n); in_valid = (n % 2 == 0);
      chk("fill_alt", M_FILL | M_O2 | M_O2V, 4'h0, 1'b0,
          (n >= 8) ? 4'(n - 8) : 4'h0, (n >= 8) && ((n - 8) % 2 == 0),
          (n < 8) ? 4'((n + 1) / 2) : 4'd4);
      step();
    end

    // Reset in the middle of a stream, with flush also asserted.
    do_reset();
    tap_sel = 3'd0;
    for (int c = 0; c < 5; c++) begin
      en = 1'b1; din = 4'(c + 1); in_valid = 1'b1;
      chk("mid_stream", M_FILL, 4'h0, 1'b0, 4'h0, 1'b0, 4'(c));
      step();
    end
    rst = 1'b1; flush = 1'b1; en = 1'b1; din = 4'hF; in_valid = 1'b1;
    chk("mid_pre_rst", M_FILL | M_OUT | M_OV, 4'h5, 1'b1, 4'h0, 1'b0, 4'd5);
    step();
    rst = 1'b0; flush = 1'b0; en = 1'b1; din = 4'hB; in_valid = 1'b1;
    chk("mid_rst_clear", M_ALL, 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    step();
    for (int k = 1; k <= 9; k++) begin
      en = 1'b1; din = 4'h0; in_valid = 1'b0;
      chk("mid_refill", M_O2 | M_O2V | M_FILL, 4'h0, 1'b0,
          (k == 8) ? 4'hB : 4'h0, (k == 8), (k <= 8) ? 4'd1 : 4'd0);
      step();
    end

    en = 1'b0;
    for (int w = 0; w < 5 && sb_q.size() > 0; w++) step();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
